// File: rtl/cordic_slot_scheduler.sv
// Round-robin word-slot scheduler sharing one bit-serial CORDIC engine among NREQ requesters.
// Build macro CORDIC_SCHED_STATS_EN adds the issued/bubble slot counters (tied to 0 otherwise).
module cordic_slot_scheduler #(
    parameter int WORD      = 16,
    parameter int NREQ      = 4,
    parameter int LAT_WORDS = 4,
    parameter int IDW       = 2
) (
    input  logic                 clk,
    input  logic                 sclr_n,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*WORD-1:0] req_x,
    input  logic [NREQ*WORD-1:0] req_y,
    input  logic [NREQ*WORD-1:0] req_z,
    input  logic [NREQ-1:0]      req_rot,
    output logic                 cd_sclr,
    input  logic                 cd_valid,
    output logic                 cd_xi,
    output logic                 cd_yi,
    output logic                 cd_zi,
    output logic                 cd_rot,
    input  logic                 cd_xo,
    input  logic                 cd_yo,
    input  logic                 cd_zo,
    output logic                 rsp_valid,
    output logic [IDW-1:0]       rsp_id,
    output logic [WORD-1:0]      rsp_x,
    output logic [WORD-1:0]      rsp_y,
    output logic [WORD-1:0]      rsp_z,
    output logic [31:0]          stat_issued,
    output logic [31:0]          stat_bubbles
);

    localparam int BW = $clog2(WORD);

    typedef enum logic {SYNC, RUN} state_t;

    state_t             state_q, state_d;
    logic               clr_q;
    logic [BW-1:0]      bitcnt;
    logic [IDW-1:0]     rr_ptr;
    logic [WORD-1:0]    sh_x, sh_y, sh_z;
    logic               rot_q;
    logic [WORD-1:0]    res_x, res_y, res_z;
    logic [LAT_WORDS:0] tag_occ;
    logic [IDW-1:0]     tag_id [LAT_WORDS+1];

    logic               active, boundary;
    logic               win_found;
    logic [IDW-1:0]     win_id;
    int unsigned        idx;

    // The engine clear covers the reset cycles plus the first cycle after release.
    assign cd_sclr  = clr_q | ~sclr_n;
    assign active   = cd_valid & ~cd_sclr;
    assign boundary = active && (state_q == RUN) && (bitcnt == BW'(WORD-1));

    assign cd_xi  = sh_x[0];
    assign cd_yi  = sh_y[0];
    assign cd_zi  = sh_z[0];
    assign cd_rot = rot_q;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_d   = state_q;
        win_found = 1'b0;
        win_id    = '0;
        idx       = 0;
        req_ready = '0;
        if (state_q == SYNC && active)
            state_d = RUN;
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(rr_ptr) + k) % NREQ;
            if (!win_found && req_valid[idx]) begin
                win_found = 1'b1;
                win_id    = IDW'(idx);
            end
        end
        if (boundary && win_found)
            req_ready[win_id] = 1'b1;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!sclr_n) begin
            state_q   <= SYNC;
            clr_q     <= 1'b1;
            bitcnt    <= '0;
            rr_ptr    <= '0;
            sh_x      <= '0;
            sh_y      <= '0;
            sh_z      <= '0;
            rot_q     <= 1'b1;
            res_x     <= '0;
            res_y     <= '0;
            res_z     <= '0;
            tag_occ   <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_x     <= '0;
            rsp_y     <= '0;
            rsp_z     <= '0;
        end else begin
            clr_q     <= 1'b0;
            state_q   <= state_d;
            rsp_valid <= 1'b0;
            if (active) begin
                bitcnt <= (bitcnt == BW'(WORD-1)) ? '0 : bitcnt + 1'b1;
                res_x  <= {cd_xo, res_x[WORD-1:1]};
                res_y  <= {cd_yo, res_y[WORD-1:1]};
                res_z  <= {cd_zo, res_z[WORD-1:1]};
                if (boundary) begin
                    // Oldest tag owns the word completing on this very bit.
                    rsp_valid <= tag_occ[LAT_WORDS];
                    if (tag_occ[LAT_WORDS]) begin
                        rsp_id <= tag_id[LAT_WORDS];
                        rsp_x  <= {cd_xo, res_x[WORD-1:1]};
                        rsp_y  <= {cd_yo, res_y[WORD-1:1]};
                        rsp_z  <= {cd_zo, res_z[WORD-1:1]};
                    end
                    tag_occ <= {tag_occ[LAT_WORDS-1:0], win_found};
                    if (win_found) begin
                        sh_x   <= req_x[int'(win_id)*WORD +: WORD];
                        sh_y   <= req_y[int'(win_id)*WORD +: WORD];
                        sh_z   <= req_z[int'(win_id)*WORD +: WORD];
                        rot_q  <= req_rot[win_id];
                        rr_ptr <= (win_id == IDW'(NREQ-1)) ? '0 : win_id + 1'b1;
                    end else begin
                        sh_x  <= '0;
                        sh_y  <= '0;
                        sh_z  <= '0;
                        rot_q <= 1'b1;
                    end
                end else begin
                    sh_x <= sh_x >> 1;
                    sh_y <= sh_y >> 1;
                    sh_z <= sh_z >> 1;
                end
            end
        end
    end

    // NOTE: tag ids are payload qualified by tag_occ, so this storage needs no reset.
    always_ff @(posedge clk) begin
        if (boundary) begin
            tag_id[0] <= win_id;
            for (int i = 1; i <= LAT_WORDS; i++)
                tag_id[i] <= tag_id[i-1];
        end
    end

`ifdef CORDIC_SCHED_STATS_EN
    logic [31:0] issued_q, bubbles_q;

    always_ff @(posedge clk) begin
        if (!sclr_n) begin
            issued_q  <= '0;
            bubbles_q <= '0;
        end else if (boundary) begin
            if (win_found)
                issued_q <= issued_q + 32'd1;
            else
                bubbles_q <= bubbles_q + 32'd1;
        end
    end

    assign stat_issued  = issued_q;
    assign stat_bubbles = bubbles_q;
`else
    assign stat_issued  = '0;
    assign stat_bubbles = '0;
`endif

endmodule

// File: tb/tb_cordic_slot_scheduler.sv
// Directed bench for cordic_slot_scheduler with a behavioural bit-serial CORDIC engine model.
// Expected results are hand-computed constants compared with a +/-8 LSB tolerance.
module tb_cordic_slot_scheduler;

    localparam int WORD = 16, NREQ = 4, LAT_WORDS = 4, IDW = 2;

    logic                 clk = 1'b0;
    logic                 sclr_n;
    logic [NREQ-1:0]      req_valid, req_ready, req_rot;
    logic [NREQ*WORD-1:0] req_x, req_y, req_z;
    logic                 cd_sclr, cd_valid, cd_xi, cd_yi, cd_zi, cd_rot, cd_xo, cd_yo, cd_zo;
    logic                 rsp_valid;
    logic [IDW-1:0]       rsp_id;
    logic [WORD-1:0]      rsp_x, rsp_y, rsp_z;
    logic [31:0]          stat_issued, stat_bubbles;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    cordic_slot_scheduler #(.WORD(WORD), .NREQ(NREQ), .LAT_WORDS(LAT_WORDS), .IDW(IDW)) dut (
        .clk(clk), .sclr_n(sclr_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_x(req_x), .req_y(req_y), .req_z(req_z), .req_rot(req_rot),
        .cd_sclr(cd_sclr), .cd_valid(cd_valid),
        .cd_xi(cd_xi), .cd_yi(cd_yi), .cd_zi(cd_zi), .cd_rot(cd_rot),
        .cd_xo(cd_xo), .cd_yo(cd_yo), .cd_zo(cd_zo),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id),
        .rsp_x(rsp_x), .rsp_y(rsp_y), .rsp_z(rsp_z),
        .stat_issued(stat_issued), .stat_bubbles(stat_bubbles)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- behavioural engine: word n result streams out during word n+LAT_WORDS
    int          e_bit = 0;
    int          e_word = 0;
    logic [15:0] m_x, m_y, m_z;
    logic        m_rot;
    logic [47:0] ob [8];

    function automatic logic [15:0] to_fix(input real r);
        int v;
        v = $rtoi(r * 16384.0 + ((r >= 0.0) ? 0.5 : -0.5));
        return v[15:0];
    endfunction

    function automatic logic [47:0] engine_calc(input logic [15:0] x, input logic [15:0] y,
                                                input logic [15:0] z, input logic rot);
        real xr, yr, zr, ox, oy, oz, k;
        k  = 1.6467602581;
        xr = real'($signed(x)) / 16384.0;
        yr = real'($signed(y)) / 16384.0;
        zr = real'($signed(z)) / 16384.0;
        if (rot) begin
            ox = k * (xr * $cos(zr) - yr * $sin(zr));
            oy = k * (yr * $cos(zr) + xr * $sin(zr));
            oz = 0.0;
        end else begin
            ox = k * $sqrt(xr * xr + yr * yr);
            oy = 0.0;
            oz = zr + $atan2(yr, xr);
        end
        return {to_fix(ox), to_fix(oy), to_fix(oz)};
    endfunction

    always @(posedge clk) begin
        if (cd_sclr !== 1'b0) begin
            e_bit  <= 0;
            e_word <= 0;
        end else if (cd_valid) begin
            m_x <= {cd_xi, m_x[15:1]};
            m_y <= {cd_yi, m_y[15:1]};
            m_z <= {cd_zi, m_z[15:1]};
            if (e_bit == 0) m_rot <= cd_rot;
            if (e_bit == WORD-1) begin
                ob[e_word % 8] <= engine_calc({cd_xi, m_x[15:1]}, {cd_yi, m_y[15:1]},
                                              {cd_zi, m_z[15:1]}, m_rot);
                e_word <= e_word + 1;
                e_bit  <= 0;
            end else begin
                e_bit <= e_bit + 1;
            end
        end
    end

    assign cd_xo = (e_word >= LAT_WORDS) ? ob[(e_word - LAT_WORDS) % 8][32 + e_bit] : 1'b0;
    assign cd_yo = (e_word >= LAT_WORDS) ? ob[(e_word - LAT_WORDS) % 8][16 + e_bit] : 1'b0;
    assign cd_zo = (e_word >= LAT_WORDS) ? ob[(e_word - LAT_WORDS) % 8][e_bit]      : 1'b0;

    // ---------------- grant / response log
    int          g_cyc[$], g_id[$], g_bit[$];
    int          r_cyc[$], r_id[$];
    logic [15:0] r_x[$], r_y[$], r_z[$];

    function automatic bit close(input logic [15:0] a, input logic [15:0] e);
        int d;
        d = int'($signed(a)) - int'($signed(e));
        return (d >= -8) && (d <= 8);
    endfunction

    task automatic clear_log();
        g_cyc.delete(); g_id.delete(); g_bit.delete();
        r_cyc.delete(); r_id.delete(); r_x.delete(); r_y.delete(); r_z.delete();
    endtask

    task automatic set_req(input int i, input logic [15:0] x, input logic [15:0] y,
                           input logic [15:0] z, input logic rot);
        req_x[i*WORD +: WORD] = x;
        req_y[i*WORD +: WORD] = y;
        req_z[i*WORD +: WORD] = z;
        req_rot[i]            = rot;
    endtask

    // Observes grants/responses; drops a requester after its handshake unless hold is set.
    task automatic run_window(input int ncyc, input bit hold, input int stop_after, input int stall);
        logic [NREQ-1:0] drop;
        int              stall_start;
        drop        = '0;
        stall_start = -1000;
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clk);
            req_valid = req_valid & ~drop;
            drop      = '0;
            if (hold && g_id.size() >= stop_after) req_valid = '0;
            cd_valid = (stall > 0 && c >= stall_start && c < stall_start + stall) ? 1'b0 : 1'b1;
            #1;
            for (int i = 0; i < NREQ; i++) begin
                if (req_ready[i]) begin
                    g_cyc.push_back(cyc);
                    g_id.push_back(i);
                    g_bit.push_back(e_bit);
                    if (stall > 0 && g_id.size() == 1) stall_start = c + 5;
                end
            end
            if (!hold) drop = req_ready;
            if (rsp_valid) begin
                r_cyc.push_back(cyc);
                r_id.push_back(int'(rsp_id));
                r_x.push_back(rsp_x);
                r_y.push_back(rsp_y);
                r_z.push_back(rsp_z);
            end
        end
        req_valid = '0;
        cd_valid  = 1'b1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        sclr_n    = 1'b0;
        req_valid = '0;
        cd_valid  = 1'b1;
        repeat (2) @(negedge clk);
        sclr_n = 1'b1;
    endtask

    // ---------------- scenarios
    task automatic test_reset();
        @(negedge clk);
        sclr_n    = 1'b0;
        req_valid = '1;
        cd_valid  = 1'b1;
        repeat (2) @(negedge clk);
        n_vec++; if (req_ready !== 4'b0) begin n_err++; $display("FAIL reset_ready: got %b want 0000", req_ready); end
        n_vec++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
        n_vec++; if ({rsp_id, rsp_x, rsp_y, rsp_z} !== '0) begin n_err++;
            $display("FAIL reset_rsp_data: got id=%0d x=%h y=%h z=%h want all 0", rsp_id, rsp_x, rsp_y, rsp_z); end
        n_vec++; if ({cd_xi, cd_yi, cd_zi, cd_rot} !== 4'b0001) begin n_err++;
            $display("FAIL reset_cd_bits: got xi/yi/zi/rot=%b want 0001", {cd_xi, cd_yi, cd_zi, cd_rot}); end
        n_vec++; if (cd_sclr !== 1'b1) begin n_err++; $display("FAIL reset_cd_sclr: got %b want 1", cd_sclr); end
        n_vec++; if ({stat_issued, stat_bubbles} !== 64'd0) begin n_err++;
            $display("FAIL reset_stats: got issued=%0d bubbles=%0d want 0/0", stat_issued, stat_bubbles); end
        req_valid = '0;
        sclr_n    = 1'b1;
        #1;
        n_vec++; if (cd_sclr !== 1'b1) begin n_err++; $display("FAIL release_cd_sclr: got %b want 1", cd_sclr); end
        @(negedge clk);
        n_vec++; if (cd_sclr !== 1'b0) begin n_err++; $display("FAIL after_release_cd_sclr: got %b want 0", cd_sclr); end
    endtask

    task automatic test_single(input int stall);
        clear_log();
        set_req(0, 16'h26DD, 16'h0000, 16'h1921, 1'b1);
        req_valid = 4'b0001;
        run_window(150, 1'b0, 1, stall);
        n_vec++;
        if (g_id.size() != 1) begin n_err++; $display("FAIL single_grants: got %0d grants want 1", g_id.size()); end
        else begin
            n_vec++; if (g_id[0] != 0) begin n_err++; $display("FAIL single_grant_id: got %0d want 0", g_id[0]); end
            n_vec++; if (g_bit[0] != WORD-1) begin n_err++;
                $display("FAIL single_grant_slot: grant at bit %0d want %0d", g_bit[0], WORD-1); end
        end
        n_vec++;
        if (r_id.size() != 1) begin n_err++; $display("FAIL single_rsps: got %0d strobes want 1", r_id.size()); end
        else begin
            n_vec++; if (r_id[0] != 0) begin n_err++; $display("FAIL single_rsp_id: got %0d want 0", r_id[0]); end
            n_vec++; if (!close(r_x[0], 16'h3B21) || !close(r_y[0], 16'h187D) || !close(r_z[0], 16'h0000)) begin n_err++;
                $display("FAIL single_rsp_data: got x=%h y=%h z=%h want ~3B21 ~187D ~0000", r_x[0], r_y[0], r_z[0]); end
            if (g_id.size() == 1) begin
                n_vec++; if (r_cyc[0] - g_cyc[0] != 81 + stall) begin n_err++;
                    $display("FAIL single_latency: got %0d cycles want %0d", r_cyc[0] - g_cyc[0], 81 + stall); end
            end
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        clear_log();
        for (int i = 0; i < NREQ; i++) set_req(i, 16'h26DD >> i, 16'h0000, 16'h0000, 1'b1);
        req_valid = 4'b1111;
        run_window(180, 1'b0, NREQ, 0);
        n_vec++;
        if (g_id.size() != NREQ || r_id.size() != NREQ) begin n_err++;
            $display("FAIL b2b_counts: got %0d grants %0d rsps want 4/4", g_id.size(), r_id.size()); end
        else begin
            for (int k = 0; k < NREQ; k++) begin
                n_vec++; if (g_id[k] != k || g_cyc[k] - g_cyc[0] != 16 * k) begin n_err++;
                    $display("FAIL b2b_grant%0d: got id=%0d offset=%0d want id=%0d offset=%0d", k, g_id[k], g_cyc[k] - g_cyc[0], k, 16 * k); end
                n_vec++; if (r_id[k] != k || r_cyc[k] - g_cyc[k] != 81) begin n_err++;
                    $display("FAIL b2b_rsp%0d: got id=%0d latency=%0d want id=%0d latency=81", k, r_id[k], r_cyc[k] - g_cyc[k], k); end
                n_vec++; if (!close(r_x[k], 16'h4000 >> k) || !close(r_y[k], 16'h0) || !close(r_z[k], 16'h0)) begin n_err++;
                    $display("FAIL b2b_data%0d: got x=%h y=%h z=%h want ~%h ~0 ~0", k, r_x[k], r_y[k], r_z[k], 16'h4000 >> k); end
            end
        end
    endtask

    task automatic test_round_robin();
        do_reset();
        clear_log();
        set_req(0, 16'h1000, 16'h1000, 16'h0000, 1'b0);
        set_req(2, 16'h1000, 16'h1000, 16'h0000, 1'b0);
        req_valid = 4'b0101;
        run_window(180, 1'b1, 4, 0);
        n_vec++;
        if (g_id.size() != 4 || r_id.size() != 4) begin n_err++;
            $display("FAIL rr_counts: got %0d grants %0d rsps want 4/4", g_id.size(), r_id.size()); end
        else begin
            for (int k = 0; k < 4; k++) begin
                n_vec++; if (g_id[k] != 2 * (k % 2) || r_id[k] != 2 * (k % 2)) begin n_err++;
                    $display("FAIL rr_order%0d: got grant=%0d rsp=%0d want %0d", k, g_id[k], r_id[k], 2 * (k % 2)); end
                n_vec++; if (!close(r_x[k], 16'h2543) || !close(r_y[k], 16'h0) || !close(r_z[k], 16'h3243)) begin n_err++;
                    $display("FAIL rr_data%0d: got x=%h y=%h z=%h want ~2543 ~0 ~3243", k, r_x[k], r_y[k], r_z[k]); end
            end
        end
    endtask

    task automatic test_idle();
        int bad_bits, bad_rsp, c, exp_b;
        bad_bits = 0;
        bad_rsp  = 0;
        c        = 0;
`ifdef CORDIC_SCHED_STATS_EN
        exp_b = 10;
`else
        exp_b = 0;
`endif
        do_reset();
        while (e_word < 10 && c < 400) begin
            @(negedge clk);
            c++;
            if (cd_xi || cd_yi || cd_zi) bad_bits++;
            if (rsp_valid) bad_rsp++;
        end
        n_vec++; if (e_word != 10) begin n_err++; $display("FAIL idle_timeout: got %0d words want 10", e_word); end
        n_vec++; if (bad_bits != 0) begin n_err++; $display("FAIL idle_bits: got %0d nonzero bit cycles want 0", bad_bits); end
        n_vec++; if (bad_rsp != 0) begin n_err++; $display("FAIL idle_rsp: got %0d strobes want 0", bad_rsp); end
        n_vec++; if (stat_bubbles != 32'(exp_b) || stat_issued != 32'd0) begin n_err++;
            $display("FAIL idle_stats: got bubbles=%0d issued=%0d want %0d/0", stat_bubbles, stat_issued, exp_b); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        clear_log();
        for (int i = 0; i < 3; i++) set_req(i, 16'h26DD, 16'h0000, 16'h1921, 1'b1);
        req_valid = 4'b0111;
        run_window(70, 1'b0, 3, 0);
        n_vec++; if (g_id.size() != 3 || r_id.size() != 0) begin n_err++;
            $display("FAIL mid_inflight: got %0d grants %0d rsps want 3/0", g_id.size(), r_id.size()); end
        @(negedge clk);
        sclr_n = 1'b0;
        @(negedge clk);
        n_vec++; if (cd_sclr !== 1'b1) begin n_err++; $display("FAIL mid_cd_sclr_hi: got %b want 1", cd_sclr); end
        @(negedge clk);
        sclr_n = 1'b1;
        #1;
        n_vec++; if (cd_sclr !== 1'b1) begin n_err++; $display("FAIL mid_cd_sclr_release: got %b want 1", cd_sclr); end
        clear_log();
        run_window(150, 1'b0, 0, 0);
        n_vec++; if (cd_sclr !== 1'b0) begin n_err++; $display("FAIL mid_cd_sclr_lo: got %b want 0", cd_sclr); end
        n_vec++; if (r_id.size() != 0) begin n_err++; $display("FAIL mid_stale_rsp: got %0d strobes want 0", r_id.size()); end
        test_single(0);
    endtask

    task automatic test_stall();
        do_reset();
        test_single(5);
    endtask

    initial begin
        sclr_n    = 1'b0;
        cd_valid  = 1'b1;
        req_valid = '0;
        req_rot   = '0;
        req_x     = '0;
        req_y     = '0;
        req_z     = '0;
        test_reset();
        test_single(0);
        test_back_to_back();
        test_round_robin();
        test_idle();
        test_reset_mid();
        test_stall();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: run exceeded 200000 time units");
        $fatal(1);
    end

endmodule
